// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one instruction at a time
// from instruction memory over a req/ready handshake, holds it for
// decode/execute and computes the next PC from the controller's
// jump/pcsrc decisions.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        pcsrc,
   input  logic        jump,
   input  logic [31:0] signimm,
   input  logic [25:0] jump_index,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pcplus4,
   output logic [31:0] instr_count
);

   // Word-aligned reset PC; the low two bits of the parameter are dropped.
   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_REQ   = 2'b01,
      S_VALID = 2'b10
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [31:0] pc_r;
   logic [31:0] pc_s;
   logic [31:0] instr_r;
   logic [31:0] instr_s;
   logic [31:0] count_r;
   logic [31:0] count_s;
   logic        req_r;
   logic        req_s;
   logic        valid_r;
   logic        valid_s;
   logic [31:0] pcplus4_s;
   logic [31:0] branch_off_s;
   logic [31:0] next_pc_s;

   // Sequential successor and word-scaled branch offset of the current PC.
   always_comb begin
      pcplus4_s    = pc_r + 32'd4;
      branch_off_s = {signimm[29:0], 2'b00};
   end

   // Next-PC select: jump wins over a taken branch, otherwise fall through.
   always_comb begin
      next_pc_s = pcplus4_s;
      if (jump) begin
         next_pc_s = {pcplus4_s[31:28], jump_index, 2'b00};
      end else if (pcsrc) begin
         next_pc_s = pcplus4_s + branch_off_s;
      end else begin
         next_pc_s = pcplus4_s;
      end
   end

   // Next-state logic for the fetch FSM and the PC/instruction/counter it owns.
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      instr_s = instr_r;
      count_s = count_r;
      case (state_r)
         S_IDLE: begin
            state_s = S_REQ;
         end
         S_REQ: begin
            if (imem_ready) begin
               instr_s = imem_rdata;
               state_s = S_VALID;
            end else begin
               state_s = S_REQ;
            end
         end
         S_VALID: begin
            if (stall) begin
               state_s = S_VALID;
            end else begin
               pc_s    = next_pc_s;
               count_s = count_r + 32'd1;
               state_s = S_REQ;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // Moore outputs decoded from the next state so they can be registered.
   always_comb begin
      req_s   = 1'b0;
      valid_s = 1'b0;
      case (state_s)
         S_REQ:   req_s   = 1'b1;
         S_VALID: valid_s = 1'b1;
         default: begin
            req_s   = 1'b0;
            valid_s = 1'b0;
         end
      endcase
   end

   // State, PC, instruction, counter and output registers; reset clears asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= S_IDLE;
         pc_r    <= RESET_PC_ALIGNED;
         instr_r <= 32'h0000_0000;
         count_r <= 32'h0000_0000;
         req_r   <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         instr_r <= instr_s;
         count_r <= count_s;
         req_r   <= req_s;
         valid_r <= valid_s;
      end
   end

   assign imem_req    = req_r;
   assign imem_addr   = pc_r;
   assign pc          = pc_r;
   assign pcplus4     = pcplus4_s;
   assign instr       = instr_r;
   assign instr_valid = valid_r;
   assign instr_count = count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized run compared against a transaction-level reference model.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        pcsrc;
   logic        jump;
   logic [31:0] signimm;
   logic [25:0] jump_index;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pcplus4;
   logic [31:0] instr_count;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: phase 0 = idle after reset, 1 = waiting on memory, 2 = holding an instruction
   int          m_phase;
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_count;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .pcsrc      (pcsrc),
      .jump       (jump),
      .signimm    (signimm),
      .jump_index (jump_index),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .instr      (instr),
      .instr_valid(instr_valid),
      .pc         (pc),
      .pcplus4    (pcplus4),
      .instr_count(instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model_next(input logic [31:0] p);
      logic [31:0] seq;
      seq = p + 32'd4;
      if (jump)
         return (seq & 32'hF000_0000) + ({6'd0, jump_index} * 32'd4);
      else if (pcsrc)
         return seq + signimm * 32'd4;
      else
         return seq;
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_pc    = 32'h0000_0000;
      m_instr = 32'h0000_0000;
      m_count = 32'h0000_0000;
   endtask

   task automatic model_edge();
      if (m_phase == 0) begin
         m_phase = 1;
      end else if (m_phase == 1) begin
         if (imem_ready) begin
            m_instr = imem_rdata;
            m_phase = 2;
         end
      end else begin
         if (!stall) begin
            m_pc    = model_next(m_pc);
            m_count = m_count + 32'd1;
            m_phase = 1;
         end
      end
   endtask

   // One clock: model follows the edge, then return at the falling edge for checks/drive
   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic quiet_inputs();
      stall      = 1'b0;
      pcsrc      = 1'b0;
      jump       = 1'b0;
      signimm    = 32'h0;
      jump_index = 26'h0;
      imem_ready = 1'b1;
      imem_rdata = 32'h2008_0005;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_to_valid(input logic [31:0] target);
      bit found;
      found = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
         if (instr_valid && pc == target) found = 1'b1;
         else cycle();
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL run_to_valid: pc=%h valid=%b, required valid at %h", pc, instr_valid, target);
      end
   endtask

   task automatic test_reset();
      quiet_inputs();
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      #1;
      n_tests++;
      if ({imem_req, instr_valid} !== 2'b00 || pc !== 32'h0 || instr !== 32'h0 || instr_count !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_state: req=%b valid=%b pc=%h instr=%h cnt=%h, required all zero",
                  imem_req, instr_valid, pc, instr, instr_count);
      end
      @(negedge clk);
      reset = 1'b0;
      n_tests++;
      if (imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_cycle: req=%b required 0", imem_req);
      end
   endtask

   task automatic test_first_fetch();
      cycle();
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL first_req: req=%b addr=%h valid=%b, required 1/0/0", imem_req, imem_addr, instr_valid);
      end
      cycle();
      n_tests++;
      if (instr_valid !== 1'b1 || instr !== 32'h2008_0005 || imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL first_valid: valid=%b instr=%h req=%b, required 1/20080005/0", instr_valid, instr, imem_req);
      end
      cycle();
      n_tests++;
      if (pc !== 32'h4 || instr_count !== 32'd1 || imem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL first_retire: pc=%h cnt=%0d req=%b, required 4/1/1", pc, instr_count, imem_req);
      end
   endtask

   task automatic test_wait_states();
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_tests++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_hold[%0d]: req=%b addr=%h valid=%b, required 1/4/0", i, imem_req, imem_addr, instr_valid);
         end
      end
      imem_ready = 1'b1;
      imem_rdata = 32'h8C09_0004;
      cycle();
      n_tests++;
      if (instr_valid !== 1'b1 || instr !== 32'h8C09_0004) begin
         n_fail++;
         $display("FAIL wait_latch: valid=%b instr=%h, required 1/8c090004", instr_valid, instr);
      end
   endtask

   task automatic test_branch();
      quiet_inputs();
      do_reset();
      run_to_valid(32'h10);
      pcsrc   = 1'b1;
      signimm = 32'hFFFF_FFFE;
      cycle();
      n_tests++;
      if (imem_addr !== 32'h0C || imem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL branch_taken: addr=%h req=%b, required 0000000c/1", imem_addr, imem_req);
      end
      signimm = 32'h0000_0100;  // pcsrc still high while fetching: must be ignored
      cycle();
      n_tests++;
      if (pc !== 32'h0C || instr_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL branch_ignore_req: pc=%h valid=%b, required 0000000c/1", pc, instr_valid);
      end
      pcsrc = 1'b0;
      cycle();
      cycle();
      cycle();
      n_tests++;
      if (imem_addr !== 32'h14) begin
         n_fail++;
         $display("FAIL branch_not_taken: addr=%h, required 00000014", imem_addr);
      end
   endtask

   task automatic test_jump_priority();
      quiet_inputs();
      do_reset();
      run_to_valid(32'h0);
      jump       = 1'b1;
      jump_index = 26'h010_0004;
      cycle();
      jump = 1'b0;
      cycle();
      n_tests++;
      if (pc !== 32'h0040_0010 || instr_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL jump_setup: pc=%h valid=%b, required 00400010/1", pc, instr_valid);
      end
      jump       = 1'b1;
      pcsrc      = 1'b1;
      signimm    = 32'h0000_0040;
      jump_index = 26'h000_0100;
      cycle();
      n_tests++;
      if (imem_addr !== 32'h0000_0400) begin
         n_fail++;
         $display("FAIL jump_priority: addr=%h, required 00000400", imem_addr);
      end
   endtask

   task automatic test_stall();
      logic [31:0] held_instr;
      logic [31:0] held_count;
      quiet_inputs();
      imem_rdata = 32'h1234_5678;
      cycle();
      held_instr = 32'h1234_5678;
      held_count = m_count;
      for (int i = 0; i < 5; i++) begin
         stall      = 1'b1;
         jump       = 1'($urandom);
         pcsrc      = 1'($urandom);
         signimm    = $urandom;
         jump_index = 26'($urandom);
         imem_rdata = $urandom;
         cycle();
         n_tests++;
         if (pc !== 32'h400 || instr !== held_instr || instr_count !== held_count ||
             imem_req !== 1'b0 || instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: pc=%h instr=%h cnt=%0d req=%b valid=%b, required 00000400/%h/%0d/0/1",
                     i, pc, instr, instr_count, imem_req, instr_valid, held_instr, held_count);
         end
      end
      quiet_inputs();
      cycle();
      n_tests++;
      if (imem_addr !== 32'h404 || instr_count !== held_count + 32'd1) begin
         n_fail++;
         $display("FAIL stall_release: addr=%h cnt=%0d, required 00000404/%0d", imem_addr, instr_count, held_count + 32'd1);
      end
   endtask

   task automatic test_reset_midwait();
      bit found;
      quiet_inputs();
      do_reset();
      found = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
         if (imem_req && imem_addr == 32'h20) found = 1'b1;
         else cycle();
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL reach_req_20: addr=%h req=%b, required 00000020/1", imem_addr, imem_req);
      end
      imem_ready = 1'b0;
      cycle();
      cycle();
      imem_rdata = 32'hCAFE_F00D;
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      n_tests++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_count !== 32'h0 || pc !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset: req=%b valid=%b cnt=%0d pc=%h, required 0/0/0/0",
                  imem_req, instr_valid, instr_count, pc);
      end
      imem_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (instr !== 32'h0) begin
         n_fail++;
         $display("FAIL no_partial_latch: instr=%h, required 0", instr);
      end
      reset = 1'b0;
      cycle();
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL restart: req=%b addr=%h, required 1/0", imem_req, imem_addr);
      end
   endtask

   task automatic test_wrap();
      quiet_inputs();
      do_reset();
      run_to_valid(32'h0);
      pcsrc   = 1'b1;
      signimm = 32'hFFFF_FFFE;
      cycle();
      pcsrc = 1'b0;
      n_tests++;
      if (imem_addr !== 32'hFFFF_FFFC) begin
         n_fail++;
         $display("FAIL wrap_setup: addr=%h, required fffffffc", imem_addr);
      end
      cycle();
      n_tests++;
      if (pcplus4 !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_pcplus4: pcplus4=%h, required 0", pcplus4);
      end
      cycle();
      n_tests++;
      if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_next: addr=%h req=%b, required 0/1", imem_addr, imem_req);
      end
   endtask

   task automatic test_random();
      quiet_inputs();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         stall      = ($urandom_range(0, 3) == 0);
         imem_ready = ($urandom_range(0, 2) != 0);
         imem_rdata = $urandom;
         jump       = ($urandom_range(0, 4) == 0);
         pcsrc      = 1'($urandom);
         signimm    = $urandom;
         jump_index = 26'($urandom);
         cycle();
         n_tests++;
         if (imem_req !== (m_phase == 1) || instr_valid !== (m_phase == 2) ||
             pc !== m_pc || imem_addr !== m_pc || pcplus4 !== m_pc + 32'd4 ||
             instr !== m_instr || instr_count !== m_count) begin
            n_fail++;
            $display("FAIL random[%0d]: req=%b valid=%b pc=%h addr=%h instr=%h cnt=%0d, required %b/%b/%h/%h/%h/%0d",
                     i, imem_req, instr_valid, pc, imem_addr, instr, instr_count,
                     (m_phase == 1), (m_phase == 2), m_pc, m_pc, m_instr, m_count);
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      quiet_inputs();
      model_reset();
      test_reset();
      test_first_fetch();
      test_wait_states();
      test_branch();
      test_jump_priority();
      test_stall();
      test_reset_midwait();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main decoder/ALU-decoder controller.
- Holds the PC and runs a request/ready handshake with instruction memory.
- Presents one instruction at a time to decode/execute.
- Consumes the controller's pcsrc and jump outputs, plus the sign-extended immediate and jump index, to compute the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset. Bits [1:0] are ignored and forced to 0.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  downstream not ready; hold the current instruction.
- pcsrc  input  1  branch taken, from the controller (branch&zero | blt&lessthan).
- jump  input  1  jump, from the controller.
- signimm  input  32  sign-extended immediate of the current instruction.
- jump_index  input  26  instr[25:0] of the current instruction.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; equals pc.
- imem_ready  input  1  memory has data this cycle.
- imem_rdata  input  32  instruction word, sampled when imem_req & imem_ready.
- instr  output  32  latched current instruction.
- instr_valid  output  1  instr is valid for decode/execute.
- pc  output  32  address of the current instruction.
- pcplus4  output  32  pc + 4, combinational.
- instr_count  output  32  number of instructions retired.

Behaviour:
- Reset (asynchronous, any state):
  - state=S_IDLE, pc=RESET_PC with [1:0]=0.
  - instr=0, instr_valid=0, instr_count=0, imem_req=0.
- FSM states: S_IDLE, S_REQ, S_VALID. Outputs are Moore-style.
  - S_IDLE: imem_req=0. Next edge goes to S_REQ unconditionally, so there is exactly one idle cycle after reset deasserts.
  - S_REQ: imem_req=1, imem_addr=pc, instr_valid=0.
    - If imem_ready=1 at the edge: instr<=imem_rdata, go to S_VALID.
    - Otherwise stay in S_REQ, with addr and req held stable (wait states allowed, unbounded).
  - S_VALID: imem_req=0, instr_valid=1.
    - If stall=1: hold pc, instr and state.
    - If stall=0 at the edge: pc<=next_pc, instr_count<=instr_count+1 (wraps modulo 2^32), go to S_REQ.
- next_pc (evaluated only in S_VALID with stall=0; jump has priority over pcsrc):
  - jump=1: {pcplus4[31:28], jump_index, 2'b00}.
  - else pcsrc=1: pcplus4 + (signimm << 2), 32-bit modulo, wrap-around allowed.
  - else: pcplus4.
- Input sampling rules:
  - pcsrc, jump, signimm and jump_index are ignored outside S_VALID and while stall=1.
  - imem_ready and imem_rdata are ignored outside S_REQ.
  - pc[1:0] is always 0.
- Latency:
  - First instr_valid is asserted 2 edges after reset deasserts, given imem_ready=1.
  - Minimum throughput is 1 instruction per 2 cycles. Each memory wait cycle adds 1.
- pc at 32'hFFFF_FFFC with a sequential next goes to 32'h0000_0000.
- Reset during S_REQ wait or during a stall:
  - instr_valid, imem_req and the counter clear immediately, without waiting for a clock edge.
  - No partial instruction is latched.

Test Plan:
- Reset, RESET_PC=0, imem_ready tied 1, rdata=32'h2008_0005 -> imem_req rises 1 cycle after reset release, addr=0. instr_valid=1 next cycle with instr=32'h2008_0005. With stall=0, pc=4 and instr_count=1.
- Wait states: imem_ready low 3 cycles in S_REQ -> imem_req and addr held at 4, instr_valid=0 throughout. Data is latched on the 4th cycle.
- Taken branch: pc=0x10, pcsrc=1, signimm=32'hFFFF_FFFE -> next imem_addr=0x0C. Same case with pcsrc=0 -> 0x14.
- Jump priority: pc=0x0040_0010, jump=1, pcsrc=1, jump_index=26'h000_0100 -> next addr=0x0000_0400.
- Stall: stall=1 for 5 cycles in S_VALID -> pc, instr and instr_count unchanged, imem_req=0. The release cycle advances pc by 4.
- Reset asserted mid-wait in S_REQ at pc=0x20 -> outputs clear asynchronously and pc=RESET_PC. After release, fetch restarts at RESET_PC; wrap check: pc=32'hFFFF_FFFC, sequential next -> addr=0.
